// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// The master side belongs to the fetch unit; the slave side is its environment.
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [5:0]        if_opcode;
    logic [ADDR_W-1:0] if_pc4;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc4,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc4,
        output imem_ack, imem_rdata, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a one-entry IF/ID register.
// It fetches one word at a time over req/ack and supports branch redirect and flush.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              kill_q, kill_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    logic slot_free;
    logic capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // A redirect takes priority over everything; the stale response of a
    // killed request is dropped, and its address stays on the bus until that
    // response arrives.
    always_comb begin
        slot_free = ~valid_q | ~bus.stall;
        capture   = (state_q == REQ) & bus.imem_ack & ~kill_q & ~bus.branch_taken;

        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;

        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (bus.imem_ack && !kill_q) state_d = HOLD;
            HOLD:    if (slot_free) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (valid_q && !bus.stall) valid_d = 1'b0;
        if ((state_q == REQ) && bus.imem_ack) kill_d = 1'b0;

        if (capture) begin
            valid_d = 1'b1;
            instr_d = bus.imem_rdata;
            pc4_d   = pc_q + STEP;
            pc_d    = pc_q + STEP;
        end

        if (bus.branch_taken) begin
            state_d = REQ;
            pc_d    = bus.branch_target & ALIGN_MK;
            valid_d = 1'b0;
            if ((state_q == REQ) && !bus.imem_ack) kill_d = 1'b1;
        end

        addr_d = ((state_q == REQ) && !bus.imem_ack) ? addr_q : pc_d;
    end

    always_comb begin
        bus.imem_req  = (state_q == REQ);
        bus.imem_addr = addr_q;
        bus.if_valid  = valid_q;
        bus.if_instr  = instr_q;
        bus.if_opcode = instr_q[31:26];
        bus.if_pc4    = pc4_q;
    end
endmodule
